// File: rtl/freq_meter_ctrl_pkg.sv
// freq_meter_ctrl_pkg: shared clock rate, default gate length and sequencer state encoding
package freq_meter_ctrl_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEF_GATE_CYCLES = CLK_HZ;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_GATE, ST_LATCH, ST_WAIT_ACK} state_t;
endpackage

// File: rtl/freq_meter_ctrl_sig_sync_edge.sv
// sig_sync_edge: multi-flop synchronizer for sig_in followed by a rising-edge pulse detector
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic sig_in,
  output logic pulse
);
  logic [SYNC_STAGES:0] sh;
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) sh <= '0;
    else sh <= {sh[SYNC_STAGES-1:0], sig_in};
  assign pulse = sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];
endmodule

// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl: gated edge-count sequencer with saturating counter and valid/ready result handoff
module freq_meter_ctrl
  import freq_meter_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CLR_CYCLES  = 10,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             gate_out,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic [CNT_W-1:0] cnt;
  logic ovf_flag, edge_p, tc_done;
  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk50 (clk50),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .pulse (edge_p)
  );
  always_comb tc_done = (state == ST_CLEAR) ? tcnt == TW'(CLR_CYCLES - 1) : tcnt == TW'(GATE_CYCLES - 1);
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_CLEAR;
      ST_CLEAR:    if (tc_done) state_nx = ST_GATE;
      ST_GATE:     if (tc_done) state_nx = ST_LATCH;
      ST_LATCH:    state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK: if (result_ready) state_nx = continuous ? ST_CLEAR : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end
  // one phase counter serves both CLEAR and GATE; it restarts on every state change
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= ((state == ST_CLEAR || state == ST_GATE) && state_nx == state) ? tcnt + TW'(1) : '0;
    end
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (state == ST_CLEAR) begin
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (state == ST_GATE && edge_p) begin
      if (&cnt) ovf_flag <= 1'b1;
      else cnt <= cnt + CNT_W'(1);
    end
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (state == ST_LATCH) begin
      result   <= cnt;
      overflow <= ovf_flag;
    end
  assign result_valid = state == ST_WAIT_ACK;
  assign gate_out     = state == ST_GATE;
  assign busy         = state != ST_IDLE;
endmodule

// File: tb/tb_freq_meter_ctrl.sv
// tb_freq_meter_ctrl: scoreboard bench driving 8-bit and 4-bit counter instances in lockstep
module tb_freq_meter_ctrl;
  logic clk50 = 0, rst_n = 1, sig_in = 0, start = 0, continuous = 0, result_ready = 1;
  logic gate8, busy8, v8, o8, gate4, busy4, v4, o4;
  logic [7:0] r8;
  logic [3:0] r4;
  int n_cmp = 0, n_bad = 0, n_rx = 0;
  int per = 0, ph = 0;
  logic lvl = 0;
  typedef struct packed {logic [7:0] c8; logic o8; logic [3:0] c4; logic o4;} exp_t;
  exp_t q[$];

  freq_meter_ctrl #(.GATE_CYCLES(100), .CLR_CYCLES(2), .CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk50(clk50), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
    .gate_out(gate8), .busy(busy8), .result(r8), .result_valid(v8),
    .result_ready(result_ready), .overflow(o8));
  freq_meter_ctrl #(.GATE_CYCLES(100), .CLR_CYCLES(2), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk50(clk50), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
    .gate_out(gate4), .busy(busy4), .result(r4), .result_valid(v4),
    .result_ready(result_ready), .overflow(o4));

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic push_exp(input int e);
    exp_t x;
    x.c8 = (e > 255) ? 8'd255 : 8'(e);
    x.o8 = e > 255;
    x.c4 = (e > 15) ? 4'd15 : 4'(e);
    x.o4 = e > 15;
    q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic set_sig(input int p, input logic l);
    per = p;
    lvl = l;
    repeat (20) tick();
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk50);
      ok = v8;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk50);
      ok = !busy8;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic measure(input int e);
    push_exp(e);
    pulse_start();
    wait_valid();
    @(negedge clk50);
    chk("busy_after_ack", busy8, 0);
    chk("valid_after_ack", v8, 0);
  endtask

  initial forever begin
    @(posedge clk50);
    #1;
    if (per > 0) begin
      ph = (ph + 1) % per;
      sig_in = ph < per / 2;
    end else sig_in = lvl;
  end

  initial forever begin
    exp_t x;
    @(negedge clk50);
    if (rst_n && v8 && result_ready) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        x = q.pop_front();
        chk("result8", r8, x.c8);
        chk("overflow8", o8, x.o8);
        chk("valid4", v4, 1);
        chk("result4", r4, x.c4);
        chk("overflow4", o4, x.o4);
        n_rx++;
      end
    end
  end

  initial begin
    int rx0, bad;
    logic [7:0] rec;
    #5 rst_n = 0;
    repeat (3) @(negedge clk50);
    chk("rst_gate", gate8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_valid", v8, 0);
    chk("rst_result", r8, 0);
    chk("rst_overflow", o8, 0);
    tick();
    rst_n = 1;
    set_sig(10, 0);
    // exact window timing relative to the sampling edge T of start
    push_exp(10);
    pulse_start();
    for (int k = 1; k <= 104; k++) begin
      @(negedge clk50);
      if (k == 1) chk("t1_busy", busy8, 1);
      if (k == 2) chk("t1_gate_k2", gate8, 0);
      if (k == 3) chk("t1_gate_k3", gate8, 1);
      if (k == 102) chk("t1_gate_k102", gate8, 1);
      if (k == 103) chk("t1_gate_k103", gate8, 0);
      if (k == 103) chk("t1_valid_k103", v8, 0);
      if (k == 104) chk("t1_valid_k104", v8, 1);
    end
    wait_idle();
    set_sig(0, 1);
    measure(0);
    set_sig(4, 0);
    measure(25);
    set_sig(10, 0);
    measure(10);
    // held result with continuous re-arm
    continuous = 1;
    result_ready = 0;
    push_exp(10);
    push_exp(10);
    pulse_start();
    wait_valid();
    rec = r8;
    bad = 0;
    repeat (50) begin
      @(negedge clk50);
      if (!v8 || r8 !== rec || gate8) bad++;
    end
    chk("hold_stable", bad, 0);
    @(posedge clk50);
    #1 result_ready = 1;
    @(negedge clk50);
    @(negedge clk50);
    chk("rearm_valid", v8, 0);
    chk("rearm_busy", busy8, 1);
    chk("rearm_gate", gate8, 0);
    @(posedge clk50);
    #1 continuous = 0;
    wait_valid();
    wait_idle();
    // asynchronous abort mid-gate
    pulse_start();
    repeat (50) tick();
    @(negedge clk50);
    chk("pre_rst_gate", gate8, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_gate", gate8, 0);
    chk("arst_busy", busy8, 0);
    chk("arst_valid", v8, 0);
    chk("arst_result", r8, 0);
    chk("arst_result4", r4, 0);
    chk("arst_overflow4", o4, 0);
    @(posedge clk50);
    #1 rst_n = 1;
    repeat (20) tick();
    measure(10);
    // starts during CLEAR, GATE and WAIT_ACK must be dropped
    rx0 = n_rx;
    push_exp(10);
    pulse_start();
    tick();
    pulse_start();
    repeat (40) tick();
    pulse_start();
    result_ready = 0;
    wait_valid();
    @(posedge clk50);
    #1 start = 1;
    tick();
    start = 0;
    result_ready = 1;
    wait_idle();
    repeat (150) tick();
    chk("one_result", n_rx - rx0, 1);
    chk("final_busy", busy8, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
